// File: rtl/alu_iterative_exec_if.sv
// rtl/alu_iterative_exec_if.sv - request/result handshake bundle for the iterative ALU execute stage
interface alu_iterative_exec_if #(
    parameter int WIDTH = 32
);
    logic             valid_i;
    logic             ready_o;
    logic [3:0]       aluop_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             valid_o;
    logic             ready_i;
    logic [WIDTH-1:0] result_o;
    logic             zero_o;
    logic             illegal_o;

    modport slave (
        input  valid_i, aluop_i, a_i, b_i, ready_i,
        output ready_o, valid_o, result_o, zero_o, illegal_o
    );

    modport master (
        output valid_i, aluop_i, a_i, b_i, ready_i,
        input  ready_o, valid_o, result_o, zero_o, illegal_o
    );
endinterface

// File: rtl/alu_iterative_exec.sv
// rtl/alu_iterative_exec.sv - execute stage: single-cycle logic/add/compare, iterative shifter
module alu_iterative_exec #(
    parameter int WIDTH      = 32,
    parameter int SHIFT_STEP = 1
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    alu_iterative_exec_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam int KW  = $clog2(SHIFT_STEP) + 1;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLT  = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLTU = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b0111;
    localparam logic [3:0] OP_SRA  = 4'b1000;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] result_q;
    logic [SHW-1:0]   count_q;
    logic             illegal_q;

    logic             is_shift;
    logic             is_illegal;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res;
    logic [KW-1:0]    k;
    logic [SHW-1:0]   count_nxt;
    logic [WIDTH-1:0] shifted;

    assign shamt      = bus.b_i[SHW-1:0];
    assign is_shift   = (bus.aluop_i == OP_SRL) || (bus.aluop_i == OP_SLL) || (bus.aluop_i == OP_SRA);
    assign is_illegal = (bus.aluop_i > OP_SRA);

    // Shift ops resolve here only for shamt==0, where the result is just operand A.
    always_comb begin
        alu_res = '0;
        case (bus.aluop_i)
            OP_AND:  alu_res = bus.a_i & bus.b_i;
            OP_OR:   alu_res = bus.a_i | bus.b_i;
            OP_ADD:  alu_res = bus.a_i + bus.b_i;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a_i) < $signed(bus.b_i))};
            OP_XOR:  alu_res = bus.a_i ^ bus.b_i;
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (bus.a_i < bus.b_i)};
            OP_SRL, OP_SLL, OP_SRA: alu_res = bus.a_i;
            default: alu_res = '0;
        endcase
    end

    // Step size is clamped to the remaining count so the shifter only spans SHIFT_STEP bits.
    always_comb begin
        k = '0;
        if (int'(count_q) >= SHIFT_STEP) begin
            k = KW'(SHIFT_STEP);
        end else begin
            k = KW'(count_q);
        end
    end

    assign count_nxt = count_q - SHW'(k);

    always_comb begin
        shifted = '0;
        case (op_q)
            OP_SLL:  shifted = acc_q << k;
            OP_SRA:  shifted = $unsigned($signed(acc_q) >>> k);
            default: shifted = acc_q >> k;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.valid_i) begin
                    state_d = (is_shift && shamt != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (count_nxt == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.ready_o   = (state_q == IDLE);
        bus.valid_o   = (state_q == DONE);
        bus.result_o  = result_q;
        bus.zero_o    = (result_q == '0);
        bus.illegal_o = illegal_q;
    end

    // result_q only moves at accept or on the final shift step, so it is stable while DONE waits.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q      <= '0;
            acc_q     <= '0;
            result_q  <= '0;
            count_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.valid_i) begin
                        op_q      <= bus.aluop_i;
                        acc_q     <= bus.a_i;
                        count_q   <= shamt;
                        illegal_q <= is_illegal;
                        if (!(is_shift && shamt != '0)) begin
                            result_q <= alu_res;
                        end
                    end
                end
                SHIFT: begin
                    acc_q   <= shifted;
                    count_q <= count_nxt;
                    if (count_nxt == '0) begin
                        result_q <= shifted;
                    end
                end
                DONE: begin
                    if (bus.ready_i) begin
                        illegal_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_iterative_exec.sv
// tb/tb_alu_iterative_exec.sv - scoreboard bench for alu_iterative_exec at SHIFT_STEP 1 and 8
module tb_alu_iterative_exec;
    typedef struct packed {
        logic [31:0] res;
        logic        ill;
    } exp_t;

    logic clk;
    logic rst_ni;
    int   total;
    int   bad;
    exp_t q1[$];
    exp_t q8[$];

    alu_iterative_exec_if #(.WIDTH(32)) if1 ();
    alu_iterative_exec_if #(.WIDTH(32)) if8 ();

    alu_iterative_exec #(.WIDTH(32), .SHIFT_STEP(1)) dut1 (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (if1)
    );

    alu_iterative_exec #(.WIDTH(32), .SHIFT_STEP(8)) dut8 (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (if8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard: each completed handshake must match the oldest pushed expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_ni === 1'b1 && if1.valid_o === 1'b1 && if1.ready_i === 1'b1) begin
            total++;
            if (q1.size() == 0) begin
                bad++;
                $display("FAIL sb1_unexpected: result=%h with no pending expectation", if1.result_o);
            end else begin
                e = q1.pop_front();
                if (if1.result_o !== e.res || if1.illegal_o !== e.ill || if1.zero_o !== (e.res == 32'd0)) begin
                    bad++;
                    $display("FAIL sb1_result: got res=%h ill=%b zero=%b want res=%h ill=%b zero=%b",
                             if1.result_o, if1.illegal_o, if1.zero_o, e.res, e.ill, (e.res == 32'd0));
                end
            end
        end
        if (rst_ni === 1'b1 && if8.valid_o === 1'b1 && if8.ready_i === 1'b1) begin
            total++;
            if (q8.size() == 0) begin
                bad++;
                $display("FAIL sb8_unexpected: result=%h with no pending expectation", if8.result_o);
            end else begin
                e = q8.pop_front();
                if (if8.result_o !== e.res || if8.illegal_o !== e.ill || if8.zero_o !== (e.res == 32'd0)) begin
                    bad++;
                    $display("FAIL sb8_result: got res=%h ill=%b zero=%b want res=%h ill=%b zero=%b",
                             if8.result_o, if8.illegal_o, if8.zero_o, e.res, e.ill, (e.res == 32'd0));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int sel, input logic [31:0] res, input logic ill);
        exp_t e;
        e.res = res;
        e.ill = ill;
        if (sel == 1) q1.push_back(e);
        else          q8.push_back(e);
    endtask

    task automatic issue(input int sel, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, output int lat);
        int guard;
        guard = 0;
        while (((sel == 1) ? if1.ready_o : if8.ready_o) !== 1'b1 && guard < 50) begin
            step();
            guard++;
        end
        if (sel == 1) begin
            if1.valid_i = 1'b1; if1.aluop_i = op; if1.a_i = a; if1.b_i = b;
        end else begin
            if8.valid_i = 1'b1; if8.aluop_i = op; if8.a_i = a; if8.b_i = b;
        end
        step();
        if (sel == 1) if1.valid_i = 1'b0;
        else          if8.valid_i = 1'b0;
        lat = 1;
        while (((sel == 1) ? if1.valid_o : if8.valid_o) !== 1'b1 && lat < 100) begin
            step();
            lat++;
        end
    endtask

    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        case (op)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a + b;
            4'd3:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd4:    return a ^ b;
            4'd5:    return (a < b) ? 32'd1 : 32'd0;
            4'd6:    return a >> sh;
            4'd7:    return a << sh;
            4'd8:    return $unsigned($signed(a) >>> sh);
            default: return 32'd0;
        endcase
    endfunction

    task automatic test_reset();
        logic saw_valid;
        total++;
        if (if1.ready_o !== 1'b1 || if1.valid_o !== 1'b0 || if1.result_o !== 32'd0 ||
            if1.zero_o !== 1'b1 || if1.illegal_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: rdy=%b vld=%b res=%h zero=%b ill=%b want 1 0 0 1 0",
                     if1.ready_o, if1.valid_o, if1.result_o, if1.zero_o, if1.illegal_o);
        end
        rst_ni = 1'b1;
        step();
        if1.valid_i = 1'b1; if1.aluop_i = 4'b0110; if1.a_i = 32'hFFFF_FFFF; if1.b_i = 32'd16;
        step();
        if1.valid_i = 1'b0;
        step();
        step();
        total++;
        if (if1.valid_o !== 1'b0 || if1.ready_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_shift_state: vld=%b rdy=%b want 0 0", if1.valid_o, if1.ready_o);
        end
        rst_ni = 1'b0;
        #1;
        total++;
        if (if1.valid_o !== 1'b0 || if1.ready_o !== 1'b1 || if1.result_o !== 32'd0 || if1.zero_o !== 1'b1) begin
            bad++;
            $display("FAIL reset_abort: vld=%b rdy=%b res=%h zero=%b want 0 1 0 1",
                     if1.valid_o, if1.ready_o, if1.result_o, if1.zero_o);
        end
        step();
        rst_ni = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (if1.valid_o === 1'b1) saw_valid = 1'b1;
        end
        total++;
        if (saw_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_no_result: saw valid_o=%b want 0", saw_valid);
        end
    endtask

    task automatic test_add_wrap();
        int lat;
        push(1, 32'd0, 1'b0);
        issue(1, 4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, lat);
        total++;
        if (lat !== 1) begin
            bad++;
            $display("FAIL add_latency: got %0d want 1", lat);
        end
        step();
        total++;
        if (if1.ready_o !== 1'b1 || if1.valid_o !== 1'b0) begin
            bad++;
            $display("FAIL add_release: rdy=%b vld=%b want 1 0", if1.ready_o, if1.valid_o);
        end
    endtask

    task automatic test_compare();
        int lat;
        push(1, 32'd1, 1'b0);
        issue(1, 4'b0011, 32'hFFFF_FFFF, 32'h0000_0001, lat);
        total++;
        if (lat !== 1) begin bad++; $display("FAIL slt_latency: got %0d want 1", lat); end
        push(1, 32'd0, 1'b0);
        issue(1, 4'b0101, 32'hFFFF_FFFF, 32'h0000_0001, lat);
        total++;
        if (lat !== 1) begin bad++; $display("FAIL sltu_latency: got %0d want 1", lat); end
        push(1, 32'd0, 1'b0);
        issue(1, 4'b0100, 32'd5, 32'd5, lat);
        total++;
        if (lat !== 1) begin bad++; $display("FAIL xor_latency: got %0d want 1", lat); end
    endtask

    task automatic test_shift();
        int lat;
        push(1, 32'hF800_0000, 1'b0);
        issue(1, 4'b1000, 32'h8000_0000, 32'h0000_0024, lat);
        total++;
        if (lat !== 5) begin bad++; $display("FAIL sra_latency: got %0d want 5", lat); end
        push(1, 32'h8000_0000, 1'b0);
        issue(1, 4'b0111, 32'd1, 32'd31, lat);
        total++;
        if (lat !== 32) begin bad++; $display("FAIL sll_latency: got %0d want 32", lat); end
        push(1, 32'hA5A5_A5A5, 1'b0);
        issue(1, 4'b0110, 32'hA5A5_A5A5, 32'hFFFF_FFE0, lat);
        total++;
        if (lat !== 1) begin bad++; $display("FAIL srl0_latency: got %0d want 1", lat); end
        push(8, 32'h0007_FFFF, 1'b0);
        issue(8, 4'b0110, 32'hFFFF_FFFF, 32'd13, lat);
        total++;
        if (lat !== 3) begin bad++; $display("FAIL srl_step8_latency: got %0d want 3", lat); end
    endtask

    task automatic test_random();
        int lat;
        int want_lat;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 10; i++) begin
                op = 4'($urandom_range(0, 15));
                a  = $urandom;
                b  = $urandom;
                if (op >= 4'd6 && op <= 4'd8 && b[4:0] != 5'd0)
                    want_lat = 1 + ((s == 0) ? int'(b[4:0]) : (int'(b[4:0]) + 7) / 8);
                else
                    want_lat = 1;
                push((s == 0) ? 1 : 8, model(op, a, b), (op > 4'd8));
                issue((s == 0) ? 1 : 8, op, a, b, lat);
                total++;
                if (lat !== want_lat) begin
                    bad++;
                    $display("FAIL rand_latency: step=%0d op=%h b=%h got %0d want %0d",
                             (s == 0) ? 1 : 8, op, b, lat, want_lat);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int   lat;
        logic held_ok;
        logic saw_valid;
        if1.ready_i = 1'b0;
        push(1, 32'h0000_00FF, 1'b0);
        issue(1, 4'b0001, 32'h0000_00F0, 32'h0000_000F, lat);
        held_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (if1.result_o !== 32'h0000_00FF || if1.ready_o !== 1'b0 || if1.valid_o !== 1'b1)
                held_ok = 1'b0;
            if1.valid_i = ~if1.valid_i;
            if1.a_i     = $urandom;
            step();
        end
        total++;
        if (held_ok !== 1'b1) begin
            bad++;
            $display("FAIL bp_hold: stable=%b want 1", held_ok);
        end
        if1.valid_i = 1'b0;
        if1.ready_i = 1'b1;
        step();
        total++;
        if (if1.ready_o !== 1'b1 || if1.valid_o !== 1'b0 || q1.size() != 0) begin
            bad++;
            $display("FAIL bp_release: rdy=%b vld=%b pending=%0d want 1 0 0",
                     if1.ready_o, if1.valid_o, q1.size());
        end
        saw_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (if1.valid_o === 1'b1) saw_valid = 1'b1;
        end
        total++;
        if (saw_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_ignored_inputs: saw valid_o=%b want 0", saw_valid);
        end
    endtask

    task automatic test_illegal();
        int lat;
        push(1, 32'd0, 1'b1);
        issue(1, 4'b1010, 32'h1234_5678, 32'h0000_0003, lat);
        total++;
        if (lat !== 1) begin bad++; $display("FAIL illegal_latency: got %0d want 1", lat); end
        step();
        total++;
        if (if1.illegal_o !== 1'b0) begin
            bad++;
            $display("FAIL illegal_clear: illegal_o=%b want 0", if1.illegal_o);
        end
        push(1, 32'd5, 1'b0);
        issue(1, 4'b0010, 32'd2, 32'd3, lat);
        total++;
        if (lat !== 1) begin bad++; $display("FAIL after_illegal_latency: got %0d want 1", lat); end
        step();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_ni = 1'b0;
        if1.valid_i = 1'b0; if1.aluop_i = '0; if1.a_i = '0; if1.b_i = '0; if1.ready_i = 1'b1;
        if8.valid_i = 1'b0; if8.aluop_i = '0; if8.a_i = '0; if8.b_i = '0; if8.ready_i = 1'b1;
        repeat (3) step();
        test_reset();
        test_add_wrap();
        test_compare();
        test_shift();
        test_backpressure();
        test_illegal();
        test_random();
        repeat (3) step();
        total++;
        if (q1.size() != 0 || q8.size() != 0) begin
            bad++;
            $display("FAIL drain: pending q1=%0d q8=%0d want 0 0", q1.size(), q8.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
